// File: rtl/mac_tx_gen.sv
// mac_tx_gen: Ethernet MAC transmit framer. Adds optional preamble/SFD, zero-pads to
// MIN_LEN, truncates beyond MAX_LEN, appends the CRC-32 FCS LSB-first and holds off an IFG.
module mac_tx_gen #(
  parameter int MIN_LEN     = 60,
  parameter int MAX_LEN     = 1514,
  parameter int IFG_BYTES   = 12,
  parameter int PREAMBLE_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_is_crc,
  output logic        out_is_pre,
  output logic        tx_done,
  output logic        tx_oversize,
  output logic [15:0] frame_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_STREAM, S_DROP, S_PAD, S_CRC, S_IFG
  } state_t;

  localparam logic [16:0] MIN_L = 17'(MIN_LEN);
  localparam logic [16:0] MAX_L = 17'(MAX_LEN);
  localparam logic [15:0] IFG_L = 16'(IFG_BYTES);

  function automatic logic [31:0] crc32_eth_init();
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] crc32_eth_update(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc32_eth_final(input logic [31:0] crc);
    return ~crc;
  endfunction

  state_t      state_r;
  logic [2:0]  idx_r;
  logic [31:0] crc_r;
  logic [15:0] count_r;
  logic [15:0] ifg_cnt_r;
  logic        ovs_r;
  logic        tx_done_r;
  logic        tx_oversize_r;
  logic [15:0] frame_len_r;

  logic [31:0] fcs_s;
  logic [16:0] count_inc_s;
  logic        xfer_s;
  logic        in_xfer_s;

  // A truncated frame deliberately carries the complement of its correct FCS.
  assign fcs_s       = crc32_eth_final(crc_r) ^ (ovs_r ? 32'hFFFF_FFFF : 32'h0000_0000);
  assign count_inc_s = {1'b0, count_r} + 17'd1;
  assign xfer_s      = out_valid && out_ready;
  assign in_xfer_s   = in_valid && in_ready;

  assign tx_done     = tx_done_r;
  assign tx_oversize = tx_oversize_r;
  assign frame_len   = frame_len_r;

  // Output byte mux and handshakes; stream bytes pass through with zero latency.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    out_is_crc = 1'b0;
    out_is_pre = 1'b0;
    case (state_r)
      S_PRE: begin
        out_valid  = 1'b1;
        out_data   = 8'h55;
        out_is_pre = 1'b1;
      end
      S_SFD: begin
        out_valid  = 1'b1;
        out_data   = 8'hD5;
        out_is_pre = 1'b1;
      end
      S_STREAM: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
      end
      S_DROP: begin
        in_ready = 1'b1;
      end
      S_PAD: begin
        out_valid = 1'b1;
      end
      S_CRC: begin
        out_valid  = 1'b1;
        out_is_crc = 1'b1;
        case (idx_r[1:0])
          2'd0:    out_data = fcs_s[7:0];
          2'd1:    out_data = fcs_s[15:8];
          2'd2:    out_data = fcs_s[23:16];
          default: out_data = fcs_s[31:24];
        endcase
        if (idx_r == 3'd3) begin
          out_last = out_ready;
        end else begin
          out_last = 1'b0;
        end
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // Framing FSM, CRC/length accumulation and registered completion status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      idx_r         <= 3'd0;
      crc_r         <= 32'hFFFF_FFFF;
      count_r       <= 16'd0;
      ifg_cnt_r     <= 16'd0;
      ovs_r         <= 1'b0;
      tx_done_r     <= 1'b0;
      tx_oversize_r <= 1'b0;
      frame_len_r   <= 16'd0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          crc_r   <= crc32_eth_init();
          count_r <= 16'd0;
          idx_r   <= 3'd0;
          if (in_valid) begin
            state_r <= (PREAMBLE_EN != 0) ? S_PRE : S_STREAM;
          end
        end
        S_PRE: begin
          if (xfer_s) begin
            if (idx_r == 3'd6) begin
              idx_r   <= 3'd0;
              state_r <= S_SFD;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        S_SFD: begin
          if (xfer_s) begin
            state_r <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (xfer_s) begin
            crc_r   <= crc32_eth_update(crc_r, in_data);
            count_r <= count_inc_s[15:0];
            if (in_last) begin
              idx_r   <= 3'd0;
              state_r <= (count_inc_s < MIN_L) ? S_PAD : S_CRC;
            end else if (count_inc_s == MAX_L) begin
              ovs_r   <= 1'b1;
              state_r <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (in_xfer_s && in_last) begin
            idx_r   <= 3'd0;
            state_r <= S_CRC;
          end
        end
        S_PAD: begin
          if (xfer_s) begin
            crc_r   <= crc32_eth_update(crc_r, 8'h00);
            count_r <= count_inc_s[15:0];
            if (count_inc_s == MIN_L) begin
              idx_r   <= 3'd0;
              state_r <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (xfer_s) begin
            if (idx_r == 3'd3) begin
              idx_r         <= 3'd0;
              tx_done_r     <= 1'b1;
              frame_len_r   <= count_r;
              tx_oversize_r <= ovs_r;
              ovs_r         <= 1'b0;
              ifg_cnt_r     <= 16'd0;
              state_r       <= (IFG_BYTES == 0) ? S_IDLE : S_IFG;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        S_IFG: begin
          if (ifg_cnt_r == IFG_L - 16'd1) begin
            state_r <= S_IDLE;
          end else begin
            ifg_cnt_r <= ifg_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_gen.sv
// Bench for mac_tx_gen: three differently parametrised instances driven from a vector table
// and a few hand sequences, checked against a frame-level reference model.
module tb_mac_tx_gen;

  localparam int NU = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [NU];
  logic       in_last [NU];
  logic [7:0] in_data [NU];
  logic       out_ready [NU];
  logic       in_ready [NU];
  logic       out_valid [NU];
  logic [7:0] out_data [NU];
  logic       out_last [NU];
  logic       out_is_crc [NU];
  logic       out_is_pre [NU];
  logic       tx_done [NU];
  logic       tx_oversize [NU];
  logic [15:0] frame_len [NU];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_tx_gen #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_BYTES(12), .PREAMBLE_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
    .out_is_crc(out_is_crc[0]), .out_is_pre(out_is_pre[0]), .tx_done(tx_done[0]),
    .tx_oversize(tx_oversize[0]), .frame_len(frame_len[0]));

  mac_tx_gen #(.MIN_LEN(0), .MAX_LEN(1514), .IFG_BYTES(0), .PREAMBLE_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
    .out_is_crc(out_is_crc[1]), .out_is_pre(out_is_pre[1]), .tx_done(tx_done[1]),
    .tx_oversize(tx_oversize[1]), .frame_len(frame_len[1]));

  mac_tx_gen #(.MIN_LEN(60), .MAX_LEN(64), .IFG_BYTES(3), .PREAMBLE_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
    .out_is_crc(out_is_crc[2]), .out_is_pre(out_is_pre[2]), .tx_done(tx_done[2]),
    .tx_oversize(tx_oversize[2]), .frame_len(frame_len[2]));

  function automatic int p_min(input int u);
    return (u == 1) ? 0 : 60;
  endfunction
  function automatic int p_max(input int u);
    return (u == 2) ? 64 : 1514;
  endfunction
  function automatic bit p_pre(input int u);
    return (u != 1);
  endfunction

  typedef struct packed {
    logic [7:0] d;
    logic       pre;
    logic       crc;
    logic       last;
  } exp_t;

  typedef struct {
    int u; int len; int pat; bit stall;
    int x_xfers; int x_drops; int x_len; bit x_ovs;
  } vec_t;

  logic [31:0] crc_tab [256];
  logic [7:0]  frame_q [$];
  logic [7:0]  got_q [$];
  logic [7:0]  saved_q [$];
  exp_t        exp_q [$];
  int          mdl_len;
  bit          mdl_ovs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Frame-level model: truncate, pad, CRC over the pre-FCS body, then flag each byte.
  task automatic build_expected(input int u);
    logic [7:0]  body [$];
    logic [31:0] c;
    logic [31:0] fcs;
    int n;
    n = frame_q.size();
    mdl_ovs = (n > p_max(u));
    body.delete();
    for (int i = 0; i < n && i < p_max(u); i++) body.push_back(frame_q[i]);
    while (body.size() < p_min(u)) body.push_back(8'h00);
    mdl_len = body.size();
    c = 32'hFFFF_FFFF;
    foreach (body[i]) c = (c >> 8) ^ crc_tab[(c ^ {24'h0, body[i]}) & 32'hFF];
    fcs = ~c;
    if (mdl_ovs) fcs = ~fcs;
    exp_q.delete();
    if (p_pre(u)) begin
      for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
      exp_q.push_back('{8'hD5, 1'b1, 1'b0, 1'b0});
    end
    foreach (body[i]) exp_q.push_back('{body[i], 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) exp_q.push_back('{fcs[8*i +: 8], 1'b0, 1'b1, (i == 3)});
  endtask

  task automatic run_frame(input int u, input bit stall, output int xfers, output int drops,
                           output int first_cyc, output int last_cyc);
    int ip; int done_cnt; int done_cyc; int guard; bit fin; exp_t e; int sz;
    ip = 0; done_cnt = 0; done_cyc = -1; guard = 0; fin = 1'b0;
    xfers = 0; drops = 0; first_cyc = -1; last_cyc = -1;
    got_q.delete();
    sz = frame_q.size();
    while (!fin) begin
      @(negedge clk);
      in_valid[u]  = (ip < sz) && (!stall || ($urandom_range(0, 99) < 70));
      in_data[u]   = (ip < sz) ? frame_q[ip] : 8'h00;
      in_last[u]   = (ip == sz - 1);
      out_ready[u] = !stall || ($urandom_range(0, 1) == 1);
      #1;
      if (out_valid[u] && out_ready[u]) begin
        got_q.push_back(out_data[u]);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
        if (exp_q.size() == 0) begin
          chk("extra_byte", {out_data[u]}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_byte", {out_data[u], out_is_pre[u], out_is_crc[u], out_last[u]}, e);
        end
      end else if (out_valid[u]) begin
        chk("last_needs_ready", {63'h0, out_last[u]}, 64'h0);
      end
      if (in_valid[u] && in_ready[u]) begin
        if (!out_valid[u]) drops++;
        ip++;
      end
      if (tx_done[u]) begin
        done_cnt++;
        done_cyc = cyc;
        chk("frame_len", {48'h0, frame_len[u]}, mdl_len);
        chk("tx_oversize", {63'h0, tx_oversize[u]}, {63'h0, mdl_ovs});
      end
      if (done_cnt > 0 && exp_q.size() == 0) fin = 1'b1;
      guard++;
      if (guard > 3000 && !fin) begin
        chk("frame_timeout", guard, 0);
        fin = 1'b1;
      end
    end
    in_valid[u] = 1'b0;
    chk("done_count", done_cnt, 1);
    chk("done_timing", done_cyc, last_cyc + 1);
  endtask

  task automatic make_frame(input int len, input int pat);
    string s;
    s = "123456789";
    frame_q.delete();
    for (int i = 0; i < len; i++) begin
      case (pat)
        1:       frame_q.push_back(s[i]);
        2:       frame_q.push_back(8'((i * 37 + 11) & 255));
        default: frame_q.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  vec_t tbl [11];

  initial begin
    int xf; int dr; int fc; int lc; int fc2; int lc2; int n; int ip; int guard;
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end
    tbl[0]  = '{0, 24, 0, 1'b0, 72, 0, 60, 1'b0};
    tbl[1]  = '{1, 9, 1, 1'b0, 13, 0, 9, 1'b0};
    tbl[2]  = '{0, 100, 2, 1'b1, 112, 0, 100, 1'b0};
    tbl[3]  = '{0, 100, 2, 1'b0, 112, 0, 100, 1'b0};
    tbl[4]  = '{2, 80, 0, 1'b0, 76, 16, 64, 1'b1};
    tbl[5]  = '{2, 64, 0, 1'b0, 76, 0, 64, 1'b0};
    tbl[6]  = '{2, 65, 0, 1'b1, 76, 1, 64, 1'b1};
    tbl[7]  = '{2, 10, 0, 1'b1, 72, 0, 60, 1'b0};
    tbl[8]  = '{1, 1, 0, 1'b0, 5, 0, 1, 1'b0};
    tbl[9]  = '{2, 60, 0, 1'b0, 72, 0, 60, 1'b0};
    tbl[10] = '{0, 59, 0, 1'b0, 72, 0, 60, 1'b0};

    for (int u = 0; u < NU; u++) begin
      in_valid[u] = 1'b0; in_last[u] = 1'b0; in_data[u] = 8'h00; out_ready[u] = 1'b0;
    end
    rst_n = 1'b0;
    #23;
    for (int u = 0; u < NU; u++) begin
      chk("reset_outputs", {out_valid[u], in_ready[u], out_data[u], out_last[u], out_is_crc[u],
                            out_is_pre[u], tx_done[u], tx_oversize[u], frame_len[u]}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      make_frame(tbl[i].len, tbl[i].pat);
      build_expected(tbl[i].u);
      run_frame(tbl[i].u, tbl[i].stall, xf, dr, fc, lc);
      chk($sformatf("v%0d_xfers", i), xf, tbl[i].x_xfers);
      chk($sformatf("v%0d_drops", i), dr, tbl[i].x_drops);
      chk($sformatf("v%0d_len", i), {48'h0, frame_len[tbl[i].u]}, tbl[i].x_len);
      chk($sformatf("v%0d_ovs", i), {63'h0, tx_oversize[tbl[i].u]}, {63'h0, tbl[i].x_ovs});
      if (tbl[i].pat == 1 && got_q.size() == 13) begin
        chk("check_fcs", {got_q[9], got_q[10], got_q[11], got_q[12]}, 32'h2639_F4CB);
      end
      if (tbl[i].pat == 2 && tbl[i].stall) saved_q = got_q;
      if (tbl[i].pat == 2 && !tbl[i].stall) begin
        chk("stall_vs_nostall", {63'h0, (saved_q == got_q)}, 64'h1);
      end
    end

    // Back-to-back frames: IFG plus one idle cycle between last FCS and next preamble.
    make_frame(60, 0);
    build_expected(0);
    run_frame(0, 1'b0, xf, dr, fc, lc);
    make_frame(60, 0);
    build_expected(0);
    run_frame(0, 1'b0, xf, dr, fc2, lc2);
    chk("ifg_gap", fc2 - lc - 1, 13);

    // Reset mid-frame at stream byte 20, then a clean frame must follow.
    make_frame(60, 0);
    n = 0; ip = 0; guard = 0;
    while (n < 20 && guard < 500) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = frame_q[ip]; in_last[0] = 1'b0; out_ready[0] = 1'b1;
      #1;
      if (out_valid[0] && out_ready[0] && !out_is_pre[0]) n++;
      if (in_valid[0] && in_ready[0]) ip++;
      guard++;
    end
    chk("reach_byte20", n, 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {out_valid[0], in_ready[0], out_data[0], out_last[0], out_is_crc[0],
                                out_is_pre[0], tx_done[0], tx_oversize[0], frame_len[0]}, 64'h0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    make_frame(60, 0);
    build_expected(0);
    run_frame(0, 1'b0, xf, dr, fc, lc);
    chk("post_reset_xfers", xf, 72);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
